// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-mode SPI slave.
package spi_pkg;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int SCK_SYNC  = 3;
    localparam int MOSI_SYNC = 2;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

endpackage

// File: rtl/spi_sync.sv
// N-stage synchroniser with a reset level and rise/fall strobes.
module spi_sync #(
    parameter int N       = 3,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [N-1:0] stg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg <= {N{RST_VAL}};
        end else begin
            stg <= {stg[N-2:0], d};
        end
    end

    // Edges come from the last two stages, one cycle ahead of q.
    assign q    = stg[N-1];
    assign rise = stg[N-2] & ~stg[N-1];
    assign fall = ~stg[N-2] & stg[N-1];

endmodule

// File: rtl/spi_slave_mp.sv
// SPI slave with configurable width, mode and bit order, oversampled on clk.
module spi_slave_mp
    import spi_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter bit                CPOL      = 1'b0,
    parameter bit                CPHA      = 1'b0,
    parameter bit                LSB_FIRST = 1'b0,
    parameter logic [DATA_W-1:0] IDLE_FILL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_ssel,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic [7:0]        word_cnt,
    output logic              tx_underrun,
    output logic              rx_abort
);

    localparam int              CW   = $clog2(DATA_W);
    localparam logic [CW-1:0]   LAST = CW'(DATA_W - 1);
    localparam logic [1:0]      MODE = {CPOL, CPHA};

    logic sck_rise, sck_fall, sck_lvl_unused;
    logic ssel_q, ssel_rise, ssel_fall;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.N(SCK_SYNC), .RST_VAL(CPOL)) u_sck (
        .clk(clk), .rst_n(rst_n), .d(spi_sck),
        .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync #(.N(SCK_SYNC), .RST_VAL(1'b1)) u_ssel (
        .clk(clk), .rst_n(rst_n), .d(spi_ssel),
        .q(ssel_q), .rise(ssel_rise), .fall(ssel_fall)
    );

    spi_sync #(.N(MOSI_SYNC), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d(spi_mosi),
        .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t            state;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_shift, tx_buf;
    logic              tx_full, wrap_pend;
    logic              sample_rise, sample, launch, load;

    // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on falling.
    assign sample_rise = (MODE == SPI_MODE0) || (MODE == SPI_MODE3);
    assign sample      = sample_rise ? sck_rise : sck_fall;
    assign launch      = sample_rise ? sck_fall : sck_rise;
    assign load        = (state == IDLE && ssel_fall && !CPHA) ||
                         (state == ACTIVE && launch && bit_cnt == '0);

    assign tx_ready    = ~tx_full;
    assign spi_miso_oe = ~ssel_q;
    assign spi_miso    = (state == ACTIVE) &
                         (LSB_FIRST ? tx_shift[0] : tx_shift[DATA_W-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            wrap_pend   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            word_cnt    <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            tx_underrun <= 1'b0;
            rx_abort    <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            tx_underrun <= 1'b0;
            rx_abort    <= 1'b0;
            wrap_pend   <= 1'b0;

            if (wrap_pend) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
                if (word_cnt != 8'hFF) word_cnt <= word_cnt + 8'd1;
            end

            // No bypass: a write landing with an empty-buffer load waits a word.
            if (load) begin
                if (tx_full) begin
                    tx_shift <= tx_buf;
                    tx_full  <= 1'b0;
                end else begin
                    tx_shift    <= IDLE_FILL;
                    tx_underrun <= 1'b1;
                end
            end
            if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (ssel_fall) begin
                        state       <= ACTIVE;
                        frame_start <= 1'b1;
                        bit_cnt     <= '0;
                        word_cnt    <= '0;
                    end
                end
                ACTIVE: begin
                    if (ssel_rise) begin
                        state     <= IDLE;
                        frame_end <= 1'b1;
                        rx_abort  <= (bit_cnt != '0);
                    end else if (sample) begin
                        rx_shift  <= LSB_FIRST ?
                                     {mosi_q, rx_shift[DATA_W-1:1]} :
                                     {rx_shift[DATA_W-2:0], mosi_q};
                        bit_cnt   <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
                        wrap_pend <= (bit_cnt == LAST);
                    end else if (launch && bit_cnt != '0) begin
                        tx_shift <= LSB_FIRST ?
                                    {1'b0, tx_shift[DATA_W-1:1]} :
                                    {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_mp.sv
// Directed bench: one DUT per SPI mode, master modelled bit by bit.
module tb_spi_slave_mp;

    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mosi;
    logic [3:0]  sck, ssel, tx_valid;
    logic [3:0]  miso, miso_oe, tx_ready, rx_valid;
    logic [3:0]  fstart, fend, undr, abrt;
    logic [7:0]  txd0, txd1, txd2, rxd0, rxd1, rxd2;
    logic [15:0] txd3, rxd3;
    logic [7:0]  wc0, wc1, wc2, wc3;

    int checks = 0;
    int passed = 0;
    int rxv_cnt[4], und_cnt[4], abt_cnt[4], abt_lone[4], fs_cnt[4];

    always #5 clk = ~clk;

    spi_slave_mp #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0),
                   .LSB_FIRST(1'b0), .IDLE_FILL(8'h00)) u0 (
        .clk(clk), .rst_n(rst_n), .spi_sck(sck[0]), .spi_ssel(ssel[0]),
        .spi_mosi(mosi), .spi_miso(miso[0]), .spi_miso_oe(miso_oe[0]),
        .tx_data(txd0), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .rx_data(rxd0), .rx_valid(rx_valid[0]), .frame_start(fstart[0]),
        .frame_end(fend[0]), .word_cnt(wc0), .tx_underrun(undr[0]),
        .rx_abort(abrt[0]));

    spi_slave_mp #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b1),
                   .LSB_FIRST(1'b0), .IDLE_FILL(8'hC3)) u1 (
        .clk(clk), .rst_n(rst_n), .spi_sck(sck[1]), .spi_ssel(ssel[1]),
        .spi_mosi(mosi), .spi_miso(miso[1]), .spi_miso_oe(miso_oe[1]),
        .tx_data(txd1), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .rx_data(rxd1), .rx_valid(rx_valid[1]), .frame_start(fstart[1]),
        .frame_end(fend[1]), .word_cnt(wc1), .tx_underrun(undr[1]),
        .rx_abort(abrt[1]));

    spi_slave_mp #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b0),
                   .LSB_FIRST(1'b0), .IDLE_FILL(8'h00)) u2 (
        .clk(clk), .rst_n(rst_n), .spi_sck(sck[2]), .spi_ssel(ssel[2]),
        .spi_mosi(mosi), .spi_miso(miso[2]), .spi_miso_oe(miso_oe[2]),
        .tx_data(txd2), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .rx_data(rxd2), .rx_valid(rx_valid[2]), .frame_start(fstart[2]),
        .frame_end(fend[2]), .word_cnt(wc2), .tx_underrun(undr[2]),
        .rx_abort(abrt[2]));

    spi_slave_mp #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1),
                   .LSB_FIRST(1'b1), .IDLE_FILL(16'h0000)) u3 (
        .clk(clk), .rst_n(rst_n), .spi_sck(sck[3]), .spi_ssel(ssel[3]),
        .spi_mosi(mosi), .spi_miso(miso[3]), .spi_miso_oe(miso_oe[3]),
        .tx_data(txd3), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]),
        .rx_data(rxd3), .rx_valid(rx_valid[3]), .frame_start(fstart[3]),
        .frame_end(fend[3]), .word_cnt(wc3), .tx_underrun(undr[3]),
        .rx_abort(abrt[3]));

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_valid[i]) rxv_cnt[i] <= rxv_cnt[i] + 1;
            if (undr[i]) und_cnt[i] <= und_cnt[i] + 1;
            if (abrt[i]) abt_cnt[i] <= abt_cnt[i] + 1;
            if (abrt[i] && !fend[i]) abt_lone[i] <= abt_lone[i] + 1;
            if (fstart[i]) fs_cnt[i] <= fs_cnt[i] + 1;
        end
    end

    function automatic logic [15:0] get_rx(input int idx);
        case (idx)
            0: return {8'h00, rxd0};
            1: return {8'h00, rxd1};
            2: return {8'h00, rxd2};
            default: return rxd3;
        endcase
    endfunction

    function automatic logic [7:0] get_wc(input int idx);
        case (idx)
            0: return wc0;
            1: return wc1;
            2: return wc2;
            default: return wc3;
        endcase
    endfunction

    task automatic push(input int idx, input logic [15:0] val);
        int k = 0;
        @(negedge clk);
        case (idx)
            0: txd0 = val[7:0];
            1: txd1 = val[7:0];
            2: txd2 = val[7:0];
            default: txd3 = val;
        endcase
        tx_valid[idx] = 1'b1;
        while (!tx_ready[idx] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (tx_ready[idx] !== 1'b1)
            $display("FAIL push%0d timeout: tx_ready=%b want 1", idx, tx_ready[idx]);
        else passed++;
        @(negedge clk);
        tx_valid[idx] = 1'b0;
    endtask

    task automatic frame_begin(input int idx);
        @(negedge clk);
        ssel[idx] = 1'b0;
        repeat (H) @(negedge clk);
        checks++;
        if (miso_oe[idx] !== 1'b1)
            $display("FAIL oe_on%0d: got %b want 1", idx, miso_oe[idx]);
        else passed++;
    endtask

    task automatic frame_finish(input int idx);
        repeat (H) @(negedge clk);
        ssel[idx] = 1'b1;
        repeat (H) @(negedge clk);
        checks++;
        if (miso_oe[idx] !== 1'b0)
            $display("FAIL oe_off%0d: got %b want 0", idx, miso_oe[idx]);
        else passed++;
    endtask

    task automatic xfer(input int idx, input int nb, input logic [15:0] wd,
                        output logic [15:0] rd);
        bit cpol = idx[1];
        bit cpha = idx[0];
        bit lsb  = (idx == 3);
        int w    = (idx == 3) ? 16 : 8;
        rd = '0;
        for (int i = 0; i < nb; i++) begin
            int b = lsb ? i : w - 1 - i;
            if (!cpha) begin
                mosi = wd[b];
                repeat (H) @(negedge clk);
                rd[b] = miso[idx];
                sck[idx] = ~cpol;
                repeat (H) @(negedge clk);
                sck[idx] = cpol;
            end else begin
                sck[idx] = ~cpol;
                mosi = wd[b];
                repeat (H) @(negedge clk);
                rd[b] = miso[idx];
                sck[idx] = cpol;
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (rxd0 !== 8'h00 || rxd3 !== 16'h0000)
            $display("FAIL rst_rx: got %h/%h want 0", rxd0, rxd3);
        else passed++;
        checks++;
        if (tx_ready !== 4'hF) $display("FAIL rst_ready: got %b want 1111", tx_ready);
        else passed++;
        checks++;
        if (miso !== 4'h0 || miso_oe !== 4'h0)
            $display("FAIL rst_miso: got %b/%b want 0", miso, miso_oe);
        else passed++;
        checks++;
        if ((rx_valid | fstart | fend | undr | abrt) !== 4'h0)
            $display("FAIL rst_strobes: got %b want 0", rx_valid | fstart | fend | undr | abrt);
        else passed++;
        checks++;
        if (wc0 !== 8'd0) $display("FAIL rst_wcnt: got %0d want 0", wc0);
        else passed++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_mode0();
        logic [15:0] rd;
        int r0 = rxv_cnt[0];
        push(0, 16'h003C);
        frame_begin(0);
        xfer(0, 8, 16'h00A5, rd);
        frame_finish(0);
        checks++;
        if (rd[7:0] !== 8'h3C) $display("FAIL m0_miso: got %h want 3c", rd[7:0]);
        else passed++;
        checks++;
        if (rxd0 !== 8'hA5) $display("FAIL m0_rx: got %h want a5", rxd0);
        else passed++;
        checks++;
        if (rxv_cnt[0] - r0 !== 1) $display("FAIL m0_rxv: got %0d want 1", rxv_cnt[0] - r0);
        else passed++;
        checks++;
        if (wc0 !== 8'd1) $display("FAIL m0_wcnt: got %0d want 1", wc0);
        else passed++;
    endtask

    task automatic test_mode3_multi();
        logic [15:0] rxw[3] = '{16'h1234, 16'hBEEF, 16'h0001};
        logic [15:0] txw[3] = '{16'hCAFE, 16'h8001, 16'h7E55};
        logic [15:0] rd;
        int u0c = und_cnt[3];
        push(3, txw[0]);
        fork
            begin
                frame_begin(3);
                for (int i = 0; i < 3; i++) begin
                    xfer(3, 16, rxw[i], rd);
                    checks++;
                    if (rd !== txw[i]) $display("FAIL m3_miso%0d: got %h want %h", i, rd, txw[i]);
                    else passed++;
                    checks++;
                    if (rxd3 !== rxw[i]) $display("FAIL m3_rx%0d: got %h want %h", i, rxd3, rxw[i]);
                    else passed++;
                end
                frame_finish(3);
            end
            begin
                push(3, txw[1]);
                push(3, txw[2]);
            end
        join
        checks++;
        if (wc3 !== 8'd3) $display("FAIL m3_wcnt: got %0d want 3", wc3);
        else passed++;
        checks++;
        if (und_cnt[3] - u0c !== 0) $display("FAIL m3_undr: got %0d want 0", und_cnt[3] - u0c);
        else passed++;
    endtask

    task automatic test_mode1_underrun();
        logic [15:0] rd;
        int u0c = und_cnt[1];
        push(1, 16'h0096);
        frame_begin(1);
        xfer(1, 8, 16'h000F, rd);
        checks++;
        if (rd[7:0] !== 8'h96) $display("FAIL m1_miso1: got %h want 96", rd[7:0]);
        else passed++;
        checks++;
        if (und_cnt[1] - u0c !== 0) $display("FAIL m1_undr1: got %0d want 0", und_cnt[1] - u0c);
        else passed++;
        xfer(1, 8, 16'h00F0, rd);
        checks++;
        if (rd[7:0] !== 8'hC3) $display("FAIL m1_miso2: got %h want c3", rd[7:0]);
        else passed++;
        checks++;
        if (und_cnt[1] - u0c !== 1) $display("FAIL m1_undr2: got %0d want 1", und_cnt[1] - u0c);
        else passed++;
        checks++;
        if (get_rx(1) !== 16'h00F0) $display("FAIL m1_rx: got %h want f0", get_rx(1));
        else passed++;
        frame_finish(1);
        checks++;
        if (get_wc(1) !== 8'd2) $display("FAIL m1_wcnt: got %0d want 2", get_wc(1));
        else passed++;
    endtask

    task automatic test_mode2_abort();
        logic [15:0] rd;
        int f0 = fs_cnt[2];
        int a0 = abt_cnt[2];
        int r0;
        frame_begin(2);
        xfer(2, 8, 16'h0081, rd);
        frame_finish(2);
        checks++;
        if (rxd2 !== 8'h81) $display("FAIL m2_rx: got %h want 81", rxd2);
        else passed++;
        r0 = rxv_cnt[2];
        frame_begin(2);
        xfer(2, 5, 16'h00FF, rd);
        frame_finish(2);
        checks++;
        if (abt_cnt[2] - a0 !== 1) $display("FAIL m2_abort: got %0d want 1", abt_cnt[2] - a0);
        else passed++;
        checks++;
        if (abt_lone[2] !== 0) $display("FAIL m2_abort_end: got %0d want 0", abt_lone[2]);
        else passed++;
        checks++;
        if (rxd2 !== 8'h81 || rxv_cnt[2] !== r0)
            $display("FAIL m2_keep: got %h/%0d want 81/%0d", rxd2, rxv_cnt[2], r0);
        else passed++;
        checks++;
        if (get_wc(2) !== 8'd0 || fs_cnt[2] - f0 !== 2)
            $display("FAIL m2_frames: got %0d/%0d want 0/2", get_wc(2), fs_cnt[2] - f0);
        else passed++;
    endtask

    task automatic test_reset_midword();
        logic [15:0] rd;
        int r0, a0;
        push(0, 16'h0011);
        frame_begin(0);
        xfer(0, 4, 16'h00FF, rd);
        r0 = rxv_cnt[0];
        a0 = abt_cnt[0];
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_ready[0] !== 1'b1 || rx_valid[0] !== 1'b0)
            $display("FAIL mr_ready: got %b/%b want 1/0", tx_ready[0], rx_valid[0]);
        else passed++;
        checks++;
        if (rxd0 !== 8'h00 || wc0 !== 8'd0)
            $display("FAIL mr_rx: got %h/%0d want 0/0", rxd0, wc0);
        else passed++;
        checks++;
        if (miso[0] !== 1'b0 || miso_oe[0] !== 1'b0)
            $display("FAIL mr_miso: got %b/%b want 0/0", miso[0], miso_oe[0]);
        else passed++;
        ssel[0] = 1'b1;
        sck[0]  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (rxv_cnt[0] !== r0 || abt_cnt[0] !== a0)
            $display("FAIL mr_nostrobe: got %0d/%0d want %0d/%0d", rxv_cnt[0], abt_cnt[0], r0, a0);
        else passed++;
        frame_begin(0);
        xfer(0, 8, 16'h005A, rd);
        frame_finish(0);
        checks++;
        if (rxd0 !== 8'h5A || wc0 !== 8'd1)
            $display("FAIL mr_clean: got %h/%0d want 5a/1", rxd0, wc0);
        else passed++;
    endtask

    task automatic test_saturate();
        logic [15:0] rd;
        int r0 = rxv_cnt[0];
        frame_begin(0);
        for (int w = 0; w < 300; w++) begin
            xfer(0, 8, 16'(w & 8'hFF), rd);
            if (w == 254) begin
                checks++;
                if (wc0 !== 8'd255) $display("FAIL sat_255: got %0d want 255", wc0);
                else passed++;
            end
        end
        frame_finish(0);
        checks++;
        if (wc0 !== 8'd255) $display("FAIL sat_hold: got %0d want 255", wc0);
        else passed++;
        checks++;
        if (rxv_cnt[0] - r0 !== 300) $display("FAIL sat_rxv: got %0d want 300", rxv_cnt[0] - r0);
        else passed++;
        checks++;
        if (rxd0 !== 8'h2B) $display("FAIL sat_last: got %h want 2b", rxd0);
        else passed++;
    endtask

    initial begin
        rst_n    = 1'b0;
        mosi     = 1'b0;
        sck      = 4'b1100;
        ssel     = 4'hF;
        tx_valid = 4'h0;
        txd0     = 8'h00;
        txd1     = 8'h00;
        txd2     = 8'h00;
        txd3     = 16'h0000;
        test_reset();
        test_mode0();
        test_mode3_multi();
        test_mode1_underrun();
        test_mode2_abort();
        test_reset_midword();
        test_saturate();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
